// File: rtl/synch_pkg.sv
// Shared constants for the synchronizer family: flop-chain depth and default width.
package synch_pkg;

  localparam int SYNC_STAGES        = 3;
  localparam int SYNC_DEFAULT_WIDTH = 1;

endpackage : synch_pkg

// File: rtl/synch_edge_det.sv
// Single-cycle rise/fall pulse generator for an already-synchronized bit.
// fall is only generated when SYNCH_3_FALL_EN is defined; otherwise it is tied low.
module synch_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic hist_q;
  logic hist_d;

  assign hist_d = d;

  // hist starts at 0, so a bit that is already high at reset release still yields one rise
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise = d & ~hist_q;

`ifdef SYNCH_3_FALL_EN
  assign fall = ~d & hist_q;
`else
  assign fall = 1'b0;
`endif

endmodule : synch_edge_det

// File: rtl/synch_3_cdc.sv
// Multi-bit three-flop input synchronizer with rise/fall pulses on bit 0.
// Optional feature macro: SYNCH_3_FALL_EN (drives fall; otherwise fall is constant 0).
module synch_3_cdc
  import synch_pkg::*;
#(
  parameter int WIDTH = SYNC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             rise,
  output logic             fall
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Reset clears every in-flight value so nothing captured before reset reaches o
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign o = stage_q[SYNC_STAGES-1];

  synch_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (stage_q[SYNC_STAGES-1][0]),
    .rise  (rise),
    .fall  (fall)
  );

endmodule : synch_3_cdc

// File: tb/tb_synch_3_cdc.sv
// Bench for synch_3_cdc: WIDTH=1 and WIDTH=24 instances against a delay-line reference model.
module tb_synch_3_cdc;

  logic        clk = 1'b0;
  logic        reset;
  logic        i1;
  logic [23:0] i24;
  logic        o1, rise1, fall1;
  logic [23:0] o24;
  logic        rise24, fall24;

  int n_chk  = 0;
  int n_fail = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  // model: the last three sampled inputs (index 0 newest) plus previous o[0]
  logic        m1  [3];
  logic [23:0] m24 [3];
  logic        prev1, prev24;

  always #5 clk = ~clk;

  synch_3_cdc #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .i(i1), .o(o1), .rise(rise1), .fall(fall1)
  );

  synch_3_cdc #(.WIDTH(24)) dut24 (
    .clk(clk), .reset(reset), .i(i24), .o(o24), .rise(rise24), .fall(fall24)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic a, input logic [23:0] b);
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        m1[k]  = 1'b0;
        m24[k] = '0;
      end
      prev1  = 1'b0;
      prev24 = 1'b0;
    end else begin
      prev1  = m1[2];
      prev24 = m24[2][0];
      m1[2]  = m1[1];  m1[1]  = m1[0];  m1[0]  = a;
      m24[2] = m24[1]; m24[1] = m24[0]; m24[0] = b;
    end
  endtask

  task automatic check_all();
    logic ef1, ef24;
`ifdef SYNCH_3_FALL_EN
    ef1  = ~m1[2] & prev1;
    ef24 = ~m24[2][0] & prev24;
`else
    ef1  = 1'b0;
    ef24 = 1'b0;
`endif
    chk("o1",     o1,     m1[2]);
    chk("rise1",  rise1,  m1[2] & ~prev1);
    chk("fall1",  fall1,  ef1);
    chk("o24",    o24,    m24[2]);
    chk("rise24", rise24, m24[2][0] & ~prev24);
    chk("fall24", fall24, ef24);
    if (rise1 === 1'b1) rise_cnt++;
    if (fall1 === 1'b1) fall_cnt++;
  endtask

  // inputs change at the falling edge; outputs are checked at the next falling edge
  task automatic step(input logic r, input logic a, input logic [23:0] b);
    reset = r;
    i1    = a;
    i24   = b;
    @(posedge clk);
    model_edge(r, a, b);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    i1    = 1'b0;
    i24   = '0;
    for (int k = 0; k < 3; k++) begin
      m1[k] = 1'b0;
      m24[k] = '0;
    end
    prev1 = 1'b0;
    prev24 = 1'b0;
    @(negedge clk);

    // reset held with input high, then release
    rise_cnt = 0;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 24'hFFFFFF);
    chk("rst_o1", o1, 1'b0);
    chk("rst_rise_cnt", rise_cnt, 0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("rel_o1_before", o1, 1'b0);
    step(1'b0, 1'b1, '0);
    chk("rel_o1_third", o1, 1'b1);
    chk("rel_rise_third", rise1, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, '0);
    chk("rel_rise_cnt", rise_cnt, 1);

    // 0->1 step on WIDTH=1 and bus change on WIDTH=24
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0);
    rise_cnt = 0;
    fall_cnt = 0;
    step(1'b0, 1'b1, 24'hA5C3F0);
    step(1'b0, 1'b1, 24'hA5C3F0);
    chk("bus_mid", o24, 24'h000000);
    step(1'b0, 1'b1, 24'hA5C3F0);
    chk("bus_settled", o24, 24'hA5C3F0);
    chk("step_o1", o1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 24'hA5C3F0);
      chk("bus_held", o24, 24'hA5C3F0);
    end
    chk("step_rise_cnt", rise_cnt, 1);

    // 1->0 step
    fall_cnt = 0;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 24'hA5C3F0);
`ifdef SYNCH_3_FALL_EN
    chk("fall_cnt", fall_cnt, 1);
`else
    chk("fall_cnt", fall_cnt, 0);
`endif

    // toggle every cycle
    rise_cnt = 0;
    for (int k = 0; k < 6; k++) step(1'b0, k[0] ? 1'b0 : 1'b1, {24{~k[0]}});
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0);
    chk("toggle_rise_cnt", rise_cnt, 3);

    // reset one cycle after a step discards the in-flight value
    rise_cnt = 0;
    step(1'b0, 1'b1, 24'h123456);
    step(1'b1, 1'b0, 24'h000000);
    step(1'b1, 1'b0, 24'h000000);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, '0);
    chk("rst_mid_o24", o24, 24'h000000);
    chk("rst_mid_rise_cnt", rise_cnt, 0);

    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 29) == 0), 1'($urandom), 24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_synch_3_cdc

// File: doc/synch_3_cdc.md
# synch_3_cdc

Multi-bit, three-flop input synchronizer with single-cycle edge pulses. It brings asynchronous or foreign-clock signals into the local clock domain, such as request strobes, address/data buses and external resets. It sits at every clock-domain entry point of a controller (e.g. the SDRAM controller's word-access request path), one instance per signal group.

## Interface
Parameters:
- WIDTH, default 1: bit width of the synchronized vector.

Ports:
- clk  input  1: local clock; all state updates on its rising edge.
- reset  input  1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- i  input  WIDTH: asynchronous input vector.
- o  output  WIDTH: synchronized copy of i.
- rise  output  1: one-cycle pulse on a 0→1 transition of o[0].
- fall  output  1: one-cycle pulse on a 1→0 transition of o[0]. Tied 0 unless SYNCH_3_FALL_EN is defined.

## Operation
- Registers:
  - stage1, stage2, stage3, each WIDTH bits.
  - hist, 1 bit: the previous value of stage3[0].
- On each clk edge, when reset is low:
  - stage1 ← i
  - stage2 ← stage1
  - stage3 ← stage2
  - hist ← stage3[0]
- Outputs:
  - o = stage3.
  - rise = stage3[0] & ~hist.
  - fall = ~stage3[0] & hist (feature build only).
- rise/fall depend on bit 0 only. For WIDTH>1 they still track bit 0. Callers use them only with WIDTH=1.
- No per-bit coherence guarantee for multi-bit vectors. Skew between bits is tolerated; callers hold buses stable across the 3-cycle window.
- No other logic: no handshake, no enable, no glitch filtering beyond the flop chain.

## Timing
- Reset (reset=1 at an edge): stage1..3 and hist go to 0. o=0, rise=0, fall=0 from the following cycle.
  - Reset asserted mid-transfer discards all in-flight values.
  - No pulse is generated by the reset itself.
- Latency: i stable before edge N gives o=i after edge N+2 (three edges).
- rise is high for exactly the cycle following edge N+2 when o[0] changes 0→1. It is low one cycle later, provided i is unchanged. fall behaves the same way for 1→0.
- Input high when reset releases: o[0] rises three edges after release and rise pulses once, because hist starts at 0.
- Input pulse shorter than one clk period may be missed. A pulse captured for at least one edge by stage1 propagates fully and yields exactly one rise and one fall.
- Back-to-back toggles every cycle: rise and fall alternate each cycle, one cycle apart.

## Configuration
- SYNCH_3_FALL_EN defined: fall is driven as specified.
- Not defined: fall is constant 0 and its logic is removed. The port list is identical in both builds.

## Structure
- Shared package synch_pkg holds:
  - localparam SYNC_STAGES = 3.
  - localparam SYNC_DEFAULT_WIDTH = 1.
- Natural sub-module: synch_edge_det. It contains hist and generates rise/fall from a 1-bit synchronized input. It is instantiated once on stage3[0].
- The flop chain lives in the top module and is sized by SYNC_STAGES.

## Test plan
- Reset held 3 cycles with i=1 → o=0, rise=0, fall=0 throughout. After release, o[0]=1 after the 3rd edge and rise=1 for exactly one cycle.
- WIDTH=1, i stepped 0→1 at edge 10 → o=1 after edge 12. rise high only in cycle 12–13. fall never high.
- WIDTH=24, i changed from 0 to 24'hA5C3F0 and held → o=24'hA5C3F0 exactly 3 edges later, with no intermediate value after the bus has settled.
- With SYNCH_3_FALL_EN: i 1→0 → fall single-cycle pulse 3 edges later. Without the macro: fall stays 0.
- i toggled every cycle for 6 cycles → o reproduces the pattern delayed 3 cycles, and rise/fall alternate with no gaps.
- reset asserted one cycle after an i 0→1 step → o stays 0 and no rise pulse occurs during or after reset until i is re-sampled post-release.
